proc_dpath_imm_gen_multi: RTL and testbench

//  Multi-lane, buffered immediate generator for the wide-decode datapath.
//  - Takes P_NLANES instructions plus a 3-bit immediate type per lane, builds each immediate sign-extended to P_XLEN, and returns them through a 2-entry val/rdy output queue.
//  - Adds Z (CSR zimm) and SH (shift amount) types, a per-lane illegal-type flag, and a saturating illegal-type counter.
//  - Sits between decode and the operand-select muxes of the dual-issue pipeline.

---
 rtl/proc_dpath_imm_gen_multi.sv | 116 +++++++++++
 tb/tb_proc_dpath_imm_gen_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_dpath_imm_gen_multi.sv
// Multi-lane immediate generator feeding a 2-entry val/rdy output queue.
// It also flags illegal immediate types per lane and keeps a saturating count of them.
module proc_dpath_imm_gen_multi #(
  parameter int P_NLANES = 2,
  parameter int P_XLEN   = 32,
  parameter int P_CNTW   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [P_NLANES-1:0]        in_lane_en,
  input  logic [3*P_NLANES-1:0]      in_imm_type,
  input  logic [32*P_NLANES-1:0]     in_inst,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [P_XLEN*P_NLANES-1:0] out_imm,
  output logic [P_NLANES-1:0]        out_illegal,
  input  logic                       err_clear,
  output logic [P_CNTW-1:0]          err_count
);

  localparam int IW = $clog2(P_NLANES + 1);
  localparam int SW = P_CNTW + IW;

  // Returns {illegal, immediate} for a single lane.
  function automatic logic [P_XLEN:0] gen_imm(input logic [2:0] t, input logic [31:0] inst);
    logic [P_XLEN-1:0] v;
    logic              ill;
    v   = '0;
    ill = 1'b0;
    case (t)
      3'd0: v = P_XLEN'($signed(inst[31:20]));
      3'd1: v = P_XLEN'($signed({inst[31:25], inst[11:7]}));
      3'd2: v = P_XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      3'd3: v = P_XLEN'($signed({inst[31:12], 12'b0}));
      3'd4: v = P_XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      3'd5: v = P_XLEN'(inst[19:15]);
      3'd6: v = (P_XLEN == 64) ? P_XLEN'(inst[25:20]) : P_XLEN'(inst[24:20]);
      default: ill = 1'b1;
    endcase
    return {ill, v};
  endfunction

  logic [P_XLEN*P_NLANES-1:0] new_imm;
  logic [P_NLANES-1:0]        new_ill;
  logic [IW-1:0]              incr;
  logic [7*P_NLANES-1:0]      unused_opcode;

  always_comb begin
    new_imm       = '0;
    new_ill       = '0;
    incr          = '0;
    unused_opcode = '0;
    for (int i = 0; i < P_NLANES; i++) begin
      {new_ill[i], new_imm[i*P_XLEN +: P_XLEN]} = gen_imm(in_imm_type[3*i +: 3], in_inst[32*i +: 32]);
      if (!in_lane_en[i]) begin
        new_ill[i]                  = 1'b0;
        new_imm[i*P_XLEN +: P_XLEN] = '0;
      end
      if (new_ill[i]) incr = incr + IW'(1);
      unused_opcode[7*i +: 7] = in_inst[32*i +: 7];
    end
  end

  logic [P_XLEN*P_NLANES-1:0] mem_imm [2];
  logic [P_NLANES-1:0]        mem_ill [2];
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 occ;
  logic                       push, pop;

  // Handshake outputs are forced low during reset so nothing leaks before the first edge.
  assign in_rdy      = reset && (occ != 2'd2);
  assign out_val     = reset && (occ != 2'd0);
  assign out_imm     = reset ? mem_imm[rd_ptr] : '0;
  assign out_illegal = reset ? mem_ill[rd_ptr] : '0;
  assign push        = in_val && in_rdy;
  assign pop         = out_val && out_rdy;

  logic [P_CNTW-1:0] err_base;
  logic [SW-1:0]     err_sum;
  logic [P_CNTW-1:0] err_next;

  always_comb begin
    err_base = err_clear ? '0 : err_count;
    err_sum  = SW'(err_base) + SW'(push ? incr : IW'(0));
    err_next = (err_sum > SW'({P_CNTW{1'b1}})) ? {P_CNTW{1'b1}} : err_sum[P_CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < 2; e++) begin
        mem_imm[e] <= '0;
        mem_ill[e] <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= new_imm;
        mem_ill[wr_ptr] <= new_ill;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (push || err_clear) err_count <= err_next;
    end
  end

endmodule

// File: tb/tb_proc_dpath_imm_gen_multi.sv
// Table-driven bench for proc_dpath_imm_gen_multi, with a 32-bit/8-bit-count instance
// and a 64-bit/2-bit-count instance that share one stimulus stream.
module tb_proc_dpath_imm_gen_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val, in_rdy, in_rdy64;
  logic [1:0]   in_lane_en;
  logic [5:0]   in_imm_type;
  logic [63:0]  in_inst;
  logic         out_val, out_val64, out_rdy;
  logic [63:0]  out_imm;
  logic [127:0] out_imm64;
  logic [1:0]   out_illegal, out_illegal64;
  logic         err_clear;
  logic [7:0]   err_count;
  logic [1:0]   err_count64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  proc_dpath_imm_gen_multi #(.P_NLANES(2), .P_XLEN(32), .P_CNTW(8)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_lane_en(in_lane_en), .in_imm_type(in_imm_type), .in_inst(in_inst),
    .out_val(out_val), .out_rdy(out_rdy), .out_imm(out_imm), .out_illegal(out_illegal),
    .err_clear(err_clear), .err_count(err_count)
  );

  proc_dpath_imm_gen_multi #(.P_NLANES(2), .P_XLEN(64), .P_CNTW(2)) dut64 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy64),
    .in_lane_en(in_lane_en), .in_imm_type(in_imm_type), .in_inst(in_inst),
    .out_val(out_val64), .out_rdy(out_rdy), .out_imm(out_imm64), .out_illegal(out_illegal64),
    .err_clear(err_clear), .err_count(err_count64)
  );

  typedef struct {
    logic [1:0]  en;
    logic [2:0]  t0, t1;
    logic [31:0] i0, i1;
    logic [31:0] e0, e1;
    logic [63:0] f0, f1;
    logic [1:0]  ill;
    logic [7:0]  c8;
    logic [1:0]  c2;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic setBeat(input logic [1:0] en, input logic [2:0] t0, input logic [31:0] i0,
                         input logic [2:0] t1, input logic [31:0] i1);
    in_lane_en  = en;
    in_imm_type = {t1, t0};
    in_inst     = {i1, i0};
  endtask

  // Drive one beat at a falling edge, let it be accepted, return at the next falling edge.
  task automatic applyStimulus(input vec_t v);
    setBeat(v.en, v.t0, v.i0, v.t1, v.i1);
    in_val  = 1'b1;
    out_rdy = 1'b1;
    checkOutput("vec_in_rdy", {63'b0, in_rdy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput("vec_out_val", {63'b0, out_val}, 64'd1);
    checkOutput("vec_imm32_l0", {32'b0, out_imm[31:0]}, {32'b0, v.e0});
    checkOutput("vec_imm32_l1", {32'b0, out_imm[63:32]}, {32'b0, v.e1});
    checkOutput("vec_imm64_l0", out_imm64[63:0], v.f0);
    checkOutput("vec_imm64_l1", out_imm64[127:64], v.f1);
    checkOutput("vec_illegal", {62'b0, out_illegal}, {62'b0, v.ill});
    checkOutput("vec_illegal64", {62'b0, out_illegal64}, {62'b0, v.ill});
    checkOutput("vec_err8", {56'b0, err_count}, {56'b0, v.c8});
    checkOutput("vec_err2", {62'b0, err_count64}, {62'b0, v.c2});
  endtask

  initial begin
    vecs[0] = '{2'b11, 3'd0, 3'd4, 32'hFFF00093, 32'h0080006F, 32'hFFFFFFFF, 32'h00000008,
                64'hFFFFFFFFFFFFFFFF, 64'h8, 2'b00, 8'd0, 2'd0};
    vecs[1] = '{2'b11, 3'd2, 3'd5, 32'hFE000EE3, 32'h800A8073, 32'hFFFFFFFC, 32'h00000015,
                64'hFFFFFFFFFFFFFFFC, 64'h15, 2'b00, 8'd0, 2'd0};
    vecs[2] = '{2'b11, 3'd3, 3'd1, 32'h800000B7, 32'hFE112E23, 32'h80000000, 32'hFFFFFFFC,
                64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC, 2'b00, 8'd0, 2'd0};
    vecs[3] = '{2'b11, 3'd6, 3'd0, 32'h02500013, 32'h7FF00013, 32'h00000005, 32'h000007FF,
                64'h25, 64'h7FF, 2'b00, 8'd0, 2'd0};
    vecs[4] = '{2'b11, 3'd7, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                64'h0, 64'h0, 2'b11, 8'd2, 2'd2};
    vecs[5] = '{2'b01, 3'd0, 3'd7, 32'h00100093, 32'hFFFFFFFF, 32'h00000001, 32'h0,
                64'h1, 64'h0, 2'b00, 8'd2, 2'd2};
    vecs[6] = '{2'b10, 3'd7, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0,
                64'h0, 64'h0, 2'b10, 8'd3, 2'd3};
    vecs[7] = '{2'b00, 3'd0, 3'd4, 32'hFFF00093, 32'h0080006F, 32'h0, 32'h0,
                64'h0, 64'h0, 2'b00, 8'd3, 2'd3};
    vecs[8] = '{2'b11, 3'd4, 3'd2, 32'hFFDFF06F, 32'h00000463, 32'hFFFFFFFC, 32'h00000008,
                64'hFFFFFFFFFFFFFFFC, 64'h8, 2'b00, 8'd3, 2'd3};

    // Reset with a pending beat on the input: nothing must be accepted or presented.
    reset     = 1'b0;
    in_val    = 1'b1;
    out_rdy   = 1'b1;
    err_clear = 1'b0;
    setBeat(2'b11, 3'd0, 32'hFFF00093, 3'd0, 32'hFFF00093);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_val", {63'b0, out_val}, 64'd0);
    checkOutput("rst_in_rdy", {63'b0, in_rdy}, 64'd0);
    checkOutput("rst_out_imm", out_imm, 64'd0);
    checkOutput("rst_out_illegal", {62'b0, out_illegal}, 64'd0);
    checkOutput("rst_err", {56'b0, err_count}, 64'd0);
    in_val = 1'b0;
    reset  = 1'b1;
    #1;
    checkOutput("rel_in_rdy", {63'b0, in_rdy}, 64'd1);
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k]);
      checkVector(vecs[k]);
    end
    @(negedge clk);
    checkOutput("drain_out_val", {63'b0, out_val}, 64'd0);

    // Saturation of the narrow counter, then clear with and without a simultaneous beat.
    setBeat(2'b11, 3'd7, 32'h0, 3'd7, 32'h0);
    in_val = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("sat_err8", {56'b0, err_count}, 64'd5);
    checkOutput("sat_err2", {62'b0, err_count64}, 64'd3);
    err_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("clr_beat_err8", {56'b0, err_count}, 64'd2);
    checkOutput("clr_beat_err2", {62'b0, err_count64}, 64'd2);
    in_val = 1'b0;
    @(posedge clk); @(negedge clk);
    err_clear = 1'b0;
    checkOutput("clr_only_err8", {56'b0, err_count}, 64'd0);
    checkOutput("clr_only_err2", {62'b0, err_count64}, 64'd0);
    @(negedge clk);

    // Backpressure: three back-to-back beats into a stalled queue.
    out_rdy = 1'b0;
    in_val  = 1'b1;
    setBeat(2'b01, 3'd0, 32'h00100093, 3'd0, 32'h0);
    checkOutput("bp_rdy0", {63'b0, in_rdy}, 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_val1", {63'b0, out_val}, 64'd1);
    checkOutput("bp_head1", {32'b0, out_imm[31:0]}, 64'd1);
    setBeat(2'b01, 3'd0, 32'h00200093, 3'd0, 32'h0);
    checkOutput("bp_rdy1", {63'b0, in_rdy}, 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_full_rdy", {63'b0, in_rdy}, 64'd0);
    setBeat(2'b01, 3'd0, 32'h00300093, 3'd0, 32'h0);
    checkOutput("bp_hold_a", {32'b0, out_imm[31:0]}, 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_full_rdy2", {63'b0, in_rdy}, 64'd0);
    checkOutput("bp_hold_b", {32'b0, out_imm[31:0]}, 64'd1);
    out_rdy = 1'b1;
    #1;
    checkOutput("bp_no_bypass", {63'b0, in_rdy}, 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_out2", {32'b0, out_imm[31:0]}, 64'd2);
    checkOutput("bp_rdy_after_pop", {63'b0, in_rdy}, 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_out3", {32'b0, out_imm[31:0]}, 64'd3);
    checkOutput("bp_val3", {63'b0, out_val}, 64'd1);
    in_val = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("bp_empty", {63'b0, out_val}, 64'd0);

    // Reset with two illegal beats queued: they are dropped and the count clears.
    out_rdy = 1'b0;
    in_val  = 1'b1;
    setBeat(2'b11, 3'd7, 32'h0, 3'd7, 32'h0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    in_val = 1'b0;
    checkOutput("pre_rst_err8", {56'b0, err_count}, 64'd4);
    checkOutput("pre_rst_err2", {62'b0, err_count64}, 64'd3);
    checkOutput("pre_rst_full", {63'b0, in_rdy}, 64'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_rst_val", {63'b0, out_val}, 64'd0);
    checkOutput("mid_rst_err8", {56'b0, err_count}, 64'd0);
    checkOutput("mid_rst_err2", {62'b0, err_count64}, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_rdy", {63'b0, in_rdy}, 64'd1);
    checkOutput("mid_rel_val", {63'b0, out_val}, 64'd0);
    out_rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checkOutput("no_stale_val", {63'b0, out_val}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
